uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of the UART receiver.
- Captures each completed character plus its parity-fail flag as one entry in a FIFO of depth 2^ADDR_WIDTH, and presents it to the host on a valid/ready read port.
- Provides an overflow flag, level/threshold status and a character-timeout indication, like a classic 16550-style RX path.

Parameters:
- DATA_WIDTH, 8: character width; matches the receiver data width.
- ADDR_WIDTH, 4: log2 of FIFO depth (default depth 16).
- THRESH, 8: level at or above which thresh asserts; legal range 1..2^ADDR_WIDTH.
- TIMEOUT_CYCLES, 640: idle rx_clk cycles with data pending before timeout asserts (4 characters at 16x oversample); must be >= 1.

Ports:
- rx_clk  in  1  receive clock, same domain as the receiver.
- rst_n  in  1  reset, asynchronous, active-low.
- in_data  in  DATA_WIDTH  received character.
- in_valid  in  1  one-cycle strobe: in_data/in_err valid.
- in_err  in  1  parity/frame fail for this character.
- flush  in  1  synchronous FIFO clear.
- ovf_clr  in  1  clear sticky overflow.
- rd_ready  in  1  host accepts head entry.
- rd_valid  out  1  head entry present (= !empty).
- rd_data  out  DATA_WIDTH  head character.
- rd_err  out  1  head character error flag.
- level  out  ADDR_WIDTH+1  entries stored, 0..2^ADDR_WIDTH.
- full  out  1  level == 2^ADDR_WIDTH.
- empty  out  1  level == 0.
- thresh  out  1  level >= THRESH.
- overflow  out  1  sticky: a character was dropped.
- timeout  out  1  data pending and idle for TIMEOUT_CYCLES.

Behaviour:
- Reset: pointers 0, level 0, empty=1, full=0, rd_valid=0, thresh=0, overflow=0, timeout=0, timeout counter 0. rd_data/rd_err are don't-care while rd_valid=0; storage is not reset.
- Storage: DATA_WIDTH+1 bits per entry. Write/read pointers are ADDR_WIDTH+1 bits with an extra wrap bit. full/empty are derived from pointer compare; level = wr_ptr - rd_ptr, modulo 2^(ADDR_WIDTH+1).
- Read port is first-word-fall-through: rd_data/rd_err reflect mem[rd_ptr] combinationally. Pop occurs on rd_valid && rd_ready at the clock edge. rd_ready while empty has no effect.
- Push occurs on in_valid && (!full || pop). The entry becomes visible on rd_valid the cycle after the write edge. There is no empty bypass: write latency is 1 cycle.
- Simultaneous push and pop when full: both happen; level stays 2^ADDR_WIDTH.
- Simultaneous push and pop when empty: pop is ignored (rd_valid=0); push happens.
- Overflow: in_valid && full && !pop drops the character, FIFO is unchanged, overflow <= 1 next edge.
  - overflow is cleared by ovf_clr.
  - If set and clear occur in the same cycle, set wins.
  - flush does not clear overflow.
- flush has priority over push and pop in its cycle: pointers <= 0, timeout counter <= 0, timeout <= 0. An in_valid in the same cycle is discarded without setting overflow.
- Pointer wrap: pointers wrap from 2^(ADDR_WIDTH+1)-1 to 0 with no special case.
- Timeout counter, width clog2(TIMEOUT_CYCLES+1), evaluated each edge:
  - Cleared if flush, push, pop or empty.
  - Otherwise increments, saturating at TIMEOUT_CYCLES.
  - timeout is registered: timeout = (counter == TIMEOUT_CYCLES).
  - timeout deasserts on the edge after any push, pop or flush.
- thresh and level are combinational from the pointers; they update on the same edge as push/pop.
- in_valid is assumed to be a single-cycle strobe per character. Back-to-back strobes on consecutive cycles are legal and are each processed.

Optional Feature:
- UART_RX_FIFO_ERR_DROP_EN defined: characters with in_err=1 are not stored and do not affect the timeout counter.
  - A sticky err_seen output port (1 bit, reset 0) sets on such a drop and clears with ovf_clr; set wins.
  - Dropping an errored character while full does not set overflow.
  - rd_err is tied to 0.
- Macro undefined: errored characters are stored with rd_err=1, and err_seen does not exist.

Test Plan:
- Reset, then push 0x41, 0x42, 0x43 (in_err=0) with rd_ready=0 -> level=3, rd_valid=1, rd_data=0x41. Then rd_ready=1 for 3 cycles -> pops 0x41, 0x42, 0x43 in order, then empty=1.
- Push 16 characters 0x00..0x0F, then push 0xAA -> full=1, overflow=1, 0xAA absent. Pop all -> 0x00..0x0F. Assert ovf_clr -> overflow=0. Overflow and ovf_clr in the same cycle -> overflow=1.
- When full, push 0x55 together with a pop -> level stays 16, last entry read out is 0x55. Repeat for 40 pushes to exercise pointer wrap; ordering is preserved.
- Push 0x31, then idle -> timeout rises exactly TIMEOUT_CYCLES+1 edges after the push (counter saturating). Pop -> timeout=0 next cycle. A push during the count restarts it.
- Push 0x7E with in_err=1 -> rd_err=1 with the macro undefined. With UART_RX_FIFO_ERR_DROP_EN defined -> nothing stored, err_seen=1.
- Fill to 9 entries -> thresh=1. flush with a simultaneous in_valid -> level=0, thresh=0, overflow unchanged. Assert rst_n=0 mid-stream -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the UART receiver, the RX FIFO and the host read port.
// The FIFO uses the slave modport; the receiver/host side uses master.
interface uart_rx_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_err;
  logic                  rd_ready;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_err;

  modport master (
    output in_data, in_valid, in_err, rd_ready,
    input  rd_valid, rd_data, rd_err
  );

  modport slave (
    input  in_data, in_valid, in_err, rd_ready,
    output rd_valid, rd_data, rd_err
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 16550-style receive FIFO: first-word-fall-through read port, sticky overflow,
// level/threshold status and character timeout. Define UART_RX_FIFO_ERR_DROP_EN
// to discard errored characters instead of storing them (adds err_seen).
module uart_rx_fifo #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int THRESH         = 8,
  parameter int TIMEOUT_CYCLES = 640
) (
  input  logic                rx_clk,
  input  logic                rst_n,
  uart_rx_fifo_if.slave       bus,
  input  logic                flush,
  input  logic                ovf_clr,
  output logic [ADDR_WIDTH:0] level,
  output logic                full,
  output logic                empty,
  output logic                thresh,
  output logic                overflow,
  output logic                timeout
`ifdef UART_RX_FIFO_ERR_DROP_EN
  ,
  output logic                err_seen
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [DATA_WIDTH:0]   head;
  logic [CNT_W-1:0]      idle_cnt;

  logic accept_char;
  logic push;
  logic pop;
  logic drop_full;

  // A character that is a candidate for storage; flush discards it outright.
`ifdef UART_RX_FIFO_ERR_DROP_EN
  logic err_drop;
  assign accept_char = bus.in_valid && !bus.in_err && !flush;
  assign err_drop    = bus.in_valid &&  bus.in_err && !flush;
`else
  assign accept_char = bus.in_valid && !flush;
`endif

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                  (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign level  = wr_ptr - rd_ptr;
  assign thresh = (level >= (ADDR_WIDTH + 1)'(THRESH));

  // A pop frees a slot in the same edge, so a full FIFO still accepts a push.
  assign pop       = !empty && bus.rd_ready && !flush;
  assign push      = accept_char && (!full || pop);
  assign drop_full = accept_char && full && !pop;

  assign head         = mem[rd_ptr[ADDR_WIDTH-1:0]];
  assign bus.rd_valid = !empty;
  assign bus.rd_data  = head[DATA_WIDTH-1:0];
`ifdef UART_RX_FIFO_ERR_DROP_EN
  assign bus.rd_err   = 1'b0;
`else
  assign bus.rd_err   = head[DATA_WIDTH];
`endif

  // NOTE: storage has no reset; rd_data is only meaningful while rd_valid=1,
  // and leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge rx_clk) begin
    if (push) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= {bus.in_err, bus.in_data};
    end
  end

  // Pointers carry one extra wrap bit and roll over naturally.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky flags: a new set in the same cycle as a clear takes precedence.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop_full) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_ERR_DROP_EN
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      err_seen <= 1'b0;
    end else if (err_drop) begin
      err_seen <= 1'b1;
    end else if (ovf_clr) begin
      err_seen <= 1'b0;
    end
  end
`endif

  // Idle counter runs only while data sits untouched; timeout lags it by one edge.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else if (flush) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= (idle_cnt == CNT_MAX);
      if (push || pop || empty) begin
        idle_cnt <= '0;
      end else if (idle_cnt != CNT_MAX) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus randomized bench for uart_rx_fifo against a queue-based model.
module tb_uart_rx_fifo;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int TH    = 8;
  localparam int TO    = 640;

  logic          rx_clk = 1'b0;
  logic          rst_n  = 1'b0;
  logic          flush  = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [AW:0]   level;
  logic          full, empty, thresh, overflow, timeout;
`ifdef UART_RX_FIFO_ERR_DROP_EN
  logic          err_seen;
`endif

  uart_rx_fifo_if #(.DATA_WIDTH(DW)) bus ();

  uart_rx_fifo #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .THRESH(TH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .rx_clk(rx_clk), .rst_n(rst_n), .bus(bus), .flush(flush), .ovf_clr(ovf_clr),
    .level(level), .full(full), .empty(empty), .thresh(thresh),
    .overflow(overflow), .timeout(timeout)
`ifdef UART_RX_FIFO_ERR_DROP_EN
    , .err_seen(err_seen)
`endif
  );

  always #5 rx_clk = ~rx_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of {err,data}, sticky flags and an idle count.
  logic [DW:0] q[$];
  logic        m_ovf;
  logic        m_tout;
  logic        m_errseen;
  int          m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0; m_tout = 1'b0; m_errseen = 1'b0; m_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rd_valid"}, bus.rd_valid, q.size() != 0);
    check({tag, ".empty"},    empty,        q.size() == 0);
    check({tag, ".full"},     full,         q.size() == DEPTH);
    check({tag, ".level"},    level,        q.size());
    check({tag, ".thresh"},   thresh,       q.size() >= TH);
    check({tag, ".overflow"}, overflow,     m_ovf);
    check({tag, ".timeout"},  timeout,      m_tout);
`ifdef UART_RX_FIFO_ERR_DROP_EN
    check({tag, ".err_seen"}, err_seen,     m_errseen);
`endif
    if (q.size() != 0) begin
      check({tag, ".rd_data"}, bus.rd_data, q[0][DW-1:0]);
      check({tag, ".rd_err"},  bus.rd_err,  q[0][DW]);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, then compare after the edge.
  task automatic step(input string tag, input logic v, input logic [DW-1:0] d, input logic e,
                      input logic rdy, input logic fl = 1'b0, input logic oc = 1'b0);
    bit m_empty, m_full, pop, push, acc;
    bus.in_valid = v; bus.in_data = d; bus.in_err = e; bus.rd_ready = rdy;
    flush = fl; ovf_clr = oc;
    m_empty = (q.size() == 0);
    m_full  = (q.size() == DEPTH);
    pop     = !m_empty && rdy;
    acc     = v;
`ifdef UART_RX_FIFO_ERR_DROP_EN
    if (e) acc = 1'b0;
`endif
    if (fl) begin
      q.delete();
      m_cnt = 0; m_tout = 1'b0;
      if (oc) begin m_ovf = 1'b0; m_errseen = 1'b0; end
    end else begin
      push   = acc && (!m_full || pop);
      m_tout = (m_cnt == TO);
      if (push || pop || m_empty) m_cnt = 0;
      else if (m_cnt < TO)        m_cnt = m_cnt + 1;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back({e, d});
      if (acc && m_full && !pop) m_ovf = 1'b1;
      else if (oc)               m_ovf = 1'b0;
`ifdef UART_RX_FIFO_ERR_DROP_EN
      if (v && e)   m_errseen = 1'b1;
      else if (oc)  m_errseen = 1'b0;
`endif
    end
    @(posedge rx_clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    int rise;
    logic [DW-1:0] last_rd;

    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_err = 1'b0; bus.rd_ready = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    check("reset_empty", empty, 1'b1);
    #10 rst_n = 1'b1;

    // Three pushes, then three pops in order.
    step("t1_push", 1'b1, 8'h41, 1'b0, 1'b0);
    step("t1_push", 1'b1, 8'h42, 1'b0, 1'b0);
    step("t1_push", 1'b1, 8'h43, 1'b0, 1'b0);
    check("t1_level", level, 3);
    check("t1_head", bus.rd_data, 8'h41);
    for (int i = 0; i < 3; i++) begin
      check("t1_pop_data", bus.rd_data, 8'h41 + i);
      step("t1_pop", 1'b0, '0, 1'b0, 1'b1);
    end
    check("t1_empty", empty, 1'b1);

    // Fill, overflow, drain in order, clear, then set-wins-over-clear.
    for (int i = 0; i < DEPTH; i++) step("t2_fill", 1'b1, DW'(i), 1'b0, 1'b0);
    step("t2_ovf", 1'b1, 8'hAA, 1'b0, 1'b0);
    check("t2_full", full, 1'b1);
    check("t2_overflow", overflow, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      check("t2_drain_data", bus.rd_data, DW'(i));
      step("t2_drain", 1'b0, '0, 1'b0, 1'b1);
    end
    step("t2_clr", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t2_ovf_cleared", overflow, 1'b0);
    for (int i = 0; i < DEPTH; i++) step("t2_refill", 1'b1, DW'(8'h10 + i), 1'b0, 1'b0);
    step("t2_setwins", 1'b1, 8'hAB, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t2_setwins_ovf", overflow, 1'b1);
    step("t2_clr2", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Push with pop while full, then 40 more to wrap the pointers.
    step("t3_pp", 1'b1, 8'h55, 1'b0, 1'b1);
    check("t3_level", level, DEPTH);
    for (int i = 0; i < 40; i++) step("t3_wrap", 1'b1, DW'(8'h80 + i), 1'b0, 1'b1);
    check("t3_level_wrap", level, DEPTH);
    last_rd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      last_rd = bus.rd_data;
      step("t3_drain", 1'b0, '0, 1'b0, 1'b1);
    end
    check("t3_last", last_rd, 8'h80 + 39);

    // Timeout: rises TO+1 edges after the push; a pop or a new push restarts it.
    step("t4_push", 1'b1, 8'h31, 1'b0, 1'b0);
    rise = -1;
    for (int k = 1; k <= TO + 10 && rise < 0; k++) begin
      idle("t4_idle");
      if (timeout === 1'b1) rise = k;
    end
    check("t4_rise_edges", rise, TO + 1);
    step("t4_pop", 1'b0, '0, 1'b0, 1'b1);
    idle("t4_after_pop");
    check("t4_timeout_low", timeout, 1'b0);
    step("t4_push2", 1'b1, 8'h32, 1'b0, 1'b0);
    for (int k = 0; k < 100; k++) idle("t4_count");
    step("t4_restart", 1'b1, 8'h33, 1'b0, 1'b0);
    rise = -1;
    for (int k = 1; k <= TO + 10 && rise < 0; k++) begin
      idle("t4_idle2");
      if (timeout === 1'b1) rise = k;
    end
    check("t4_restart_edges", rise, TO + 1);
    step("t4_flush", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Errored character.
    step("t5_err", 1'b1, 8'h7E, 1'b1, 1'b0);
`ifdef UART_RX_FIFO_ERR_DROP_EN
    check("t5_level", level, 0);
    check("t5_err_seen", err_seen, 1'b1);
`else
    check("t5_rd_err", bus.rd_err, 1'b1);
    check("t5_rd_data", bus.rd_data, 8'h7E);
`endif
    step("t5_flush", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Threshold, then flush with a colliding in_valid while overflow is set.
    for (int i = 0; i <= DEPTH; i++) step("t6_ovf", 1'b1, DW'(i), 1'b0, 1'b0);
    step("t6_flush", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step("t6_fill", 1'b1, DW'(8'hC0 + i), 1'b0, 1'b0);
    check("t6_thresh", thresh, 1'b1);
    step("t6_flush_push", 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    check("t6_level", level, 0);
    check("t6_thresh0", thresh, 1'b0);
    check("t6_ovf_kept", overflow, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 1) == 1), DW'($urandom), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 19) == 0));
    end

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 5; i++) step("t7_fill", 1'b1, DW'(8'h60 + i), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t7_async_reset");
    check("t7_rd_valid", bus.rd_valid, 1'b0);
    #3 rst_n = 1'b1;
    step("t7_after", 1'b1, 8'h99, 1'b0, 1'b0);
    idle("t7_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
